lmc1992_rx: RTL and testbench

- Receive end of the STE microwire link, modelling the LMC1992 volume/tone controller.
- Deserialises 11-bit commands framed by MWE_N and decodes the mixer, bass, treble, master, left and right registers.
- Applies the master and left/right volume attenuation to the 8-bit offset-binary DMA audio samples produced by the shifter's sound engine.
- Sits between the shifter's audio/microwire outputs and the board audio DAC path.

---
 rtl/lmc1992_rx.sv | 201 ++++++++++++++++++++
 tb/tb_lmc1992_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lmc1992_rx.sv
// lmc1992_rx: microwire receive end of the LMC1992 volume/tone controller model.
// Deserialises framed 11-bit commands into the mixer/tone/volume registers and
// applies master plus per-channel attenuation to offset-binary audio samples.
module lmc1992_rx #(
  parameter int unsigned CMD_BITS = 11,
  parameter logic [1:0]  DEV_ADDR = 2'b10
) (
  input  logic       clk32,
  input  logic       resb,
  input  logic       MWCK,
  input  logic       MWDATA,
  input  logic       MWE_N,
  input  logic       AUD_STB,
  input  logic [7:0] AUD_L,
  input  logic [7:0] AUD_R,
  output logic       OUT_STB,
  output logic [7:0] OUT_L,
  output logic [7:0] OUT_R,
  output logic [1:0] MIXER,
  output logic [3:0] BASS,
  output logic [3:0] TREBLE,
  output logic [5:0] MASTER,
  output logic [4:0] VOL_L,
  output logic [4:0] VOL_R,
  output logic       CMD_ERR
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned SR_W  = CMD_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Combined attenuation steps -> {mantissa[8:0], shift[4:0]}.
  function automatic logic [13:0] gain(input logic [5:0] master, input logic [4:0] vol);
    logic [6:0] n;
    logic [1:0] r;
    logic [8:0] m;
    n = 7'(6'd40 - master) + 7'(5'd20 - vol);
    r = 2'(n % 7'd3);
    case (r)
      2'd0:    m = 9'd256;
      2'd1:    m = 9'd203;
      default: m = 9'd161;
    endcase
    gain = {m, 5'(n / 7'd3)};
  endfunction

  // Signed sample times mantissa, then the two arithmetic right shifts.
  function automatic logic [7:0] scale(input logic [7:0] s, input logic [8:0] m,
                                       input logic [4:0] q);
    logic signed [17:0] prod;
    prod = $signed({{10{s[7]}}, s}) * $signed({9'd0, m});
    scale = (q >= 5'd8) ? 8'd0 : 8'((prod >>> 8) >>> q);
  endfunction

  logic            mwck_q, mwck_d, mwe_n_q, mwe_n_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      mixer_q, mixer_d;
  logic [3:0]      bass_q, bass_d, treble_q, treble_d;
  logic [5:0]      master_q, master_d;
  logic [4:0]      vol_l_q, vol_l_d, vol_r_q, vol_r_d;
  logic            cmd_err_q, cmd_err_d;

  logic            s1_vld_q, s1_vld_d;
  logic [7:0]      s1_s_l_q, s1_s_l_d, s1_s_r_q, s1_s_r_d;
  logic [8:0]      s1_m_l_q, s1_m_l_d, s1_m_r_q, s1_m_r_d;
  logic [4:0]      s1_q_l_q, s1_q_l_d, s1_q_r_q, s1_q_r_d;
  logic            out_stb_q, out_stb_d;
  logic [7:0]      out_l_q, out_l_d, out_r_q, out_r_d;

  logic            ck_rise, en_rise, en_fall;
  logic [1:0]      addr;
  logic [2:0]      func;

  assign ck_rise = MWCK & ~mwck_q;
  assign en_rise = MWE_N & ~mwe_n_q;
  assign en_fall = ~MWE_N & mwe_n_q;
  assign addr    = sr_d[SR_W-1 -: 2];
  assign func    = sr_d[SR_W-3 -: 3];

  // Microwire deserialiser and register decode on frame end.
  always_comb begin
    mwck_d    = MWCK;
    mwe_n_d   = MWE_N;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    mixer_d   = mixer_q;
    bass_d    = bass_q;
    treble_d  = treble_q;
    master_d  = master_q;
    vol_l_d   = vol_l_q;
    vol_r_d   = vol_r_q;
    cmd_err_d = 1'b0;
    if (en_fall) cnt_d = '0;
    // A clock rise coinciding with frame end still belongs to the frame.
    if (ck_rise && (!MWE_N || en_rise)) begin
      sr_d = {sr_q[SR_W-2:0], MWDATA};
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
    end
    if (en_rise) begin
      if (cnt_d >= CNT_W'(CMD_BITS) && addr == DEV_ADDR) begin
        case (func)
          3'b000: mixer_d  = sr_d[1:0];
          3'b001: bass_d   = (sr_d[3:0] > 4'd12) ? 4'd12 : sr_d[3:0];
          3'b010: treble_d = (sr_d[3:0] > 4'd12) ? 4'd12 : sr_d[3:0];
          3'b011: master_d = (sr_d[5:0] > 6'd40) ? 6'd40 : sr_d[5:0];
          3'b100: vol_r_d  = (sr_d[4:0] > 5'd20) ? 5'd20 : sr_d[4:0];
          3'b101: vol_l_d  = (sr_d[4:0] > 5'd20) ? 5'd20 : sr_d[4:0];
          default: ;
        endcase
      end else begin
        cmd_err_d = 1'b1;
      end
    end
  end

  // Two-stage attenuation pipeline; volume sampled into stage 1.
  always_comb begin
    s1_vld_d  = AUD_STB;
    s1_s_l_d  = s1_s_l_q;
    s1_s_r_d  = s1_s_r_q;
    s1_m_l_d  = s1_m_l_q;
    s1_m_r_d  = s1_m_r_q;
    s1_q_l_d  = s1_q_l_q;
    s1_q_r_d  = s1_q_r_q;
    out_stb_d = s1_vld_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    if (AUD_STB) begin
      s1_s_l_d             = AUD_L ^ 8'h80;
      s1_s_r_d             = AUD_R ^ 8'h80;
      {s1_m_l_d, s1_q_l_d} = gain(master_q, vol_l_q);
      {s1_m_r_d, s1_q_r_d} = gain(master_q, vol_r_q);
    end
    if (s1_vld_q) begin
      out_l_d = scale(s1_s_l_q, s1_m_l_q, s1_q_l_q) ^ 8'h80;
      out_r_d = scale(s1_s_r_q, s1_m_r_q, s1_q_r_q) ^ 8'h80;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk32) begin
    if (!resb) begin
      mwck_q    <= 1'b1;
      mwe_n_q   <= 1'b1;
      sr_q      <= '0;
      cnt_q     <= '0;
      mixer_q   <= 2'b01;
      bass_q    <= 4'd6;
      treble_q  <= 4'd6;
      master_q  <= 6'd40;
      vol_l_q   <= 5'd20;
      vol_r_q   <= 5'd20;
      cmd_err_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_s_l_q  <= '0;
      s1_s_r_q  <= '0;
      s1_m_l_q  <= '0;
      s1_m_r_q  <= '0;
      s1_q_l_q  <= '0;
      s1_q_r_q  <= '0;
      out_stb_q <= 1'b0;
      out_l_q   <= 8'h80;
      out_r_q   <= 8'h80;
    end else begin
      mwck_q    <= mwck_d;
      mwe_n_q   <= mwe_n_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      mixer_q   <= mixer_d;
      bass_q    <= bass_d;
      treble_q  <= treble_d;
      master_q  <= master_d;
      vol_l_q   <= vol_l_d;
      vol_r_q   <= vol_r_d;
      cmd_err_q <= cmd_err_d;
      s1_vld_q  <= s1_vld_d;
      s1_s_l_q  <= s1_s_l_d;
      s1_s_r_q  <= s1_s_r_d;
      s1_m_l_q  <= s1_m_l_d;
      s1_m_r_q  <= s1_m_r_d;
      s1_q_l_q  <= s1_q_l_d;
      s1_q_r_q  <= s1_q_r_d;
      out_stb_q <= out_stb_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
    end
  end

  assign OUT_STB = out_stb_q;
  assign OUT_L   = out_l_q;
  assign OUT_R   = out_r_q;
  assign MIXER   = mixer_q;
  assign BASS    = bass_q;
  assign TREBLE  = treble_q;
  assign MASTER  = master_q;
  assign VOL_L   = vol_l_q;
  assign VOL_R   = vol_r_q;
  assign CMD_ERR = cmd_err_q;

endmodule

// File: tb/tb_lmc1992_rx.sv
// tb_lmc1992_rx: directed and randomized checks of lmc1992_rx against a
// behavioural model of the command decode and the dB attenuation law.
module tb_lmc1992_rx;

  logic       clk32 = 1'b0;
  logic       resb = 1'b0;
  logic       MWCK = 1'b0, MWDATA = 1'b0, MWE_N = 1'b1, AUD_STB = 1'b0;
  logic [7:0] AUD_L = 8'h80, AUD_R = 8'h80;
  logic       OUT_STB, CMD_ERR;
  logic [7:0] OUT_L, OUT_R;
  logic [1:0] MIXER;
  logic [3:0] BASS, TREBLE;
  logic [5:0] MASTER;
  logic [4:0] VOL_L, VOL_R;

  int n_checks = 0;
  int n_pass   = 0;

  // Model register file
  int m_mixer, m_bass, m_treble, m_master, m_voll, m_volr;

  lmc1992_rx dut (
    .clk32(clk32), .resb(resb), .MWCK(MWCK), .MWDATA(MWDATA), .MWE_N(MWE_N),
    .AUD_STB(AUD_STB), .AUD_L(AUD_L), .AUD_R(AUD_R), .OUT_STB(OUT_STB),
    .OUT_L(OUT_L), .OUT_R(OUT_R), .MIXER(MIXER), .BASS(BASS), .TREBLE(TREBLE),
    .MASTER(MASTER), .VOL_L(VOL_L), .VOL_R(VOL_R), .CMD_ERR(CMD_ERR)
  );

  always #5 clk32 = ~clk32;

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Attenuation law: 2 dB master steps plus 2 dB channel steps, 6 dB per
  // shift, mantissa approximating the leftover 0/-2/-4 dB.
  function automatic int atten(input int smp, input int master, input int vol);
    int n, q, mm, s, p;
    n  = (40 - master) + (20 - vol);
    q  = n / 3;
    mm = (n % 3 == 0) ? 256 : (n % 3 == 1) ? 203 : 161;
    s  = smp - 128;
    p  = (s * mm) >>> 8;
    p  = (q >= 8) ? 0 : (p >>> q);
    return (p & 255) ^ 128;
  endfunction

  function automatic logic [31:0] mk(input int func, input int data);
    return {21'd0, 2'b10, 3'(func), 6'(data)};
  endfunction

  task automatic model_reset();
    m_mixer = 1; m_bass = 6; m_treble = 6; m_master = 40; m_voll = 20; m_volr = 20;
  endtask

  // Frame outcome from the bits actually clocked in: last 11 form the command.
  task automatic model_frame(input logic [31:0] bits, input int n, output bit err);
    logic [10:0] w;
    w = bits[10:0];
    err = 1'b0;
    if (n < 11 || w[10:9] != 2'b10) err = 1'b1;
    else case (w[8:6])
      3'd0: m_mixer  = int'(w[1:0]);
      3'd1: m_bass   = min_i(int'(w[3:0]), 12);
      3'd2: m_treble = min_i(int'(w[3:0]), 12);
      3'd3: m_master = min_i(int'(w[5:0]), 40);
      3'd4: m_volr   = min_i(int'(w[4:0]), 20);
      3'd5: m_voll   = min_i(int'(w[4:0]), 20);
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_mixer"},  32'(MIXER),  32'(m_mixer));
    check({tag, "_bass"},   32'(BASS),   32'(m_bass));
    check({tag, "_treble"}, 32'(TREBLE), 32'(m_treble));
    check({tag, "_master"}, 32'(MASTER), 32'(m_master));
    check({tag, "_voll"},   32'(VOL_L),  32'(m_voll));
    check({tag, "_volr"},   32'(VOL_R),  32'(m_volr));
  endtask

  // Send n bits MSB first; optionally merge last clock rise with frame end and
  // optionally issue an audio strobe in the frame-end cycle (old volume applies).
  task automatic send_frame(input string tag, input logic [31:0] bits, input int n,
                            input bit merge, input bit with_aud,
                            input logic [7:0] al, input logic [7:0] ar);
    bit err;
    int el, er;
    el = atten(int'(al), m_master, m_voll);
    er = atten(int'(ar), m_master, m_volr);
    MWE_N = 1'b0;
    tick();
    for (int i = n - 1; i >= 0; i--) begin
      MWDATA = bits[i];
      MWCK = 1'b1;
      if (merge && i == 0) break;
      tick();
      MWCK = 1'b0;
      tick();
    end
    MWE_N = 1'b1;
    AUD_STB = with_aud; AUD_L = al; AUD_R = ar;
    tick();
    MWCK = 1'b0;
    AUD_STB = 1'b0;
    model_frame(bits, n, err);
    check({tag, "_err"}, 32'(CMD_ERR), 32'(err));
    check_regs(tag);
    tick();
    check({tag, "_err_clr"}, 32'(CMD_ERR), 32'd0);
    if (with_aud) begin
      check({tag, "_astb"}, 32'(OUT_STB), 32'd1);
      check({tag, "_al"}, 32'(OUT_L), 32'(el));
      check({tag, "_ar"}, 32'(OUT_R), 32'(er));
    end
  endtask

  task automatic aud(input string tag, input logic [7:0] l, input logic [7:0] r);
    int el, er;
    el = atten(int'(l), m_master, m_voll);
    er = atten(int'(r), m_master, m_volr);
    AUD_STB = 1'b1; AUD_L = l; AUD_R = r;
    tick();
    AUD_STB = 1'b0;
    check({tag, "_stb0"}, 32'(OUT_STB), 32'd0);
    tick();
    check({tag, "_stb"}, 32'(OUT_STB), 32'd1);
    check({tag, "_l"}, 32'(OUT_L), 32'(el));
    check({tag, "_r"}, 32'(OUT_R), 32'(er));
    tick();
    check({tag, "_stb2"}, 32'(OUT_STB), 32'd0);
  endtask

  // Randomized back-to-back audio stream against per-cycle expectations.
  task automatic aud_stream(input string tag, input int len);
    bit es [0:63];
    int el [0:63];
    int er [0:63];
    for (int i = 0; i <= len; i++) begin
      if (i < len) begin
        AUD_STB = 1'($urandom_range(0, 3) != 0);
        AUD_L = 8'($urandom); AUD_R = 8'($urandom);
        es[i] = AUD_STB;
        el[i] = atten(int'(AUD_L), m_master, m_voll);
        er[i] = atten(int'(AUD_R), m_master, m_volr);
      end else AUD_STB = 1'b0;
      tick();
      if (i >= 1) begin
        check({tag, "_stb"}, 32'(OUT_STB), 32'(es[i-1]));
        if (es[i-1]) begin
          check({tag, "_l"}, 32'(OUT_L), 32'(el[i-1]));
          check({tag, "_r"}, 32'(OUT_R), 32'(er[i-1]));
        end
      end
    end
    tick();
  endtask

  initial begin
    logic [31:0] bits;
    int n;
    model_reset();
    repeat (3) tick();
    resb = 1'b1;
    check_regs("rst");
    check("rst_outl", 32'(OUT_L), 32'h80);
    check("rst_outr", 32'(OUT_R), 32'h80);
    check("rst_stb", 32'(OUT_STB), 32'd0);
    check("rst_err", 32'(CMD_ERR), 32'd0);
    tick();
    aud("unity", 8'hC0, 8'hC0);

    send_frame("m40", mk(3, 40), 11, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("m29", mk(3, 29), 11, 1'b0, 1'b0, 8'h80, 8'h80);
    aud("m29a", 8'hC0, 8'h40);
    send_frame("m40b", mk(3, 40), 11, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("vlclamp", mk(5, 63), 11, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("vr0", mk(4, 0), 11, 1'b0, 1'b0, 8'h80, 8'h80);
    aud("vr0a", 8'hFF, 8'h00);

    send_frame("short9", 32'h1FF, 9, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("badaddr", {21'd0, 2'b01, 3'd3, 6'd5}, 11, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("long13", {19'd0, 2'b01, 2'b10, 3'd1, 6'd3}, 13, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("func6", mk(6, 7), 11, 1'b0, 1'b0, 8'h80, 8'h80);
    send_frame("merge", mk(0, 2), 11, 1'b1, 1'b0, 8'h80, 8'h80);
    send_frame("samecyc", mk(3, 10), 11, 1'b0, 1'b1, 8'h20, 8'hE0);

    // Reset in the middle of a frame discards it.
    MWE_N = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      MWDATA = 1'b1; MWCK = 1'b1; tick(); MWCK = 1'b0; tick();
    end
    resb = 1'b0; MWE_N = 1'b1;
    tick();
    resb = 1'b1;
    model_reset();
    check("midrst_err", 32'(CMD_ERR), 32'd0);
    check_regs("midrst");
    send_frame("treb", mk(2, 12), 11, 1'b0, 1'b0, 8'h80, 8'h80);

    // Sample in flight when reset hits is dropped.
    AUD_STB = 1'b1; AUD_L = 8'h10; AUD_R = 8'hF0;
    tick();
    AUD_STB = 1'b0; resb = 1'b0;
    tick();
    resb = 1'b1;
    model_reset();
    check("drop_stb", 32'(OUT_STB), 32'd0);
    check("drop_l", 32'(OUT_L), 32'h80);
    tick();
    check("drop_stb2", 32'(OUT_STB), 32'd0);

    // Random frames.
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(8, 14);
      bits = $urandom;
      if ($urandom_range(0, 3) != 0) bits[10:9] = 2'b10;
      send_frame("rfrm", bits, n, 1'($urandom_range(0, 1)), 1'b0, 8'h80, 8'h80);
    end

    // Random volume settings with random audio streams.
    for (int k = 0; k < 5; k++) begin
      send_frame("rmas", mk(3, $urandom_range(0, 63)), 11, 1'b0, 1'b0, 8'h80, 8'h80);
      send_frame("rvl", mk(5, $urandom_range(0, 31)), 11, 1'b0, 1'b0, 8'h80, 8'h80);
      send_frame("rvr", mk(4, $urandom_range(0, 31)), 11, 1'b0, 1'b0, 8'h80, 8'h80);
      aud_stream("rstream", 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
